// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: core-side load/store request and response channels.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_we;
  logic [63:0] req_wdata;
  logic [7:0]  req_mask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_mask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding 64-bit data memory with fixed response latency.
module data_mem_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [63:0]   resp_rdata_q;
  logic [63:0]   mem [DEPTH];
  logic          accept;
  logic          bad;
  logic [AW-1:0] idx;
  assign accept = bus.req_valid && req_ready_q;
  assign idx    = bus.req_addr[3 +: AW];
  assign bad    = (bus.req_addr[2:0] != 3'd0) || (bus.req_addr >= 64'(DEPTH) * 64'd8);
  // Load data is snapshotted at acceptance, so later stores or input changes cannot leak in.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else
      case (state_q)
        IDLE:
          if (accept) begin
            state_q      <= (LATENCY > 1) ? WAIT : RESP;
            cnt_q        <= CW'(LATENCY - 1);
            req_ready_q  <= 1'b0;
            resp_valid_q <= (LATENCY == 1);
            resp_err_q   <= bad;
            resp_rdata_q <= (bad || bus.req_we) ? '0 : mem[idx];
          end else
            req_ready_q <= 1'b1;
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end
        end
        RESP:
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        default: state_q <= IDLE;
      endcase
  // Memory is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk)
    if (accept && bus.req_we && !bad)
      for (int i = 0; i < 8; i++)
        if (bus.req_mask[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors plus randomized traffic against a word/byte memory model.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();
  data_mem_responder_if b2 ();
  data_mem_responder #(.DEPTH(16), .LATENCY(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  data_mem_responder #(.DEPTH(16), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  data_mem_responder #(.DEPTH(16), .LATENCY(3)) u2 (.clk(clk), .rst(rst), .bus(b2));
  virtual data_mem_responder_if vif;
  int checks = 0;
  int failures = 0;
  int lat_of [3] = '{2, 1, 3};
  logic [63:0] mm [3][16];
  logic [7:0]  kn [3][16];
  typedef struct packed {
    logic [63:0] a;
    logic        we;
    logic [63:0] wd;
    logic [7:0]  m;
    logic [63:0] rd;
    logic        err;
  } vec_t;
  vec_t tbl [12];
  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endfunction
  // Reference: byte-addressed word store with per-byte "has been written" tracking.
  function automatic void model(input int d, input logic [63:0] a, input logic we,
                                input logic [63:0] wd, input logic [7:0] m,
                                output logic [63:0] rd, output logic err, output logic [63:0] cm);
    int w;
    err = (a % 8 != 0) || (a >= 64'd128);
    w   = int'(a / 8) % 16;
    rd  = '0;
    cm  = '1;
    if (!err && we)
      for (int i = 0; i < 8; i++)
        if (m[i]) begin
          mm[d][w][8*i +: 8] = wd[8*i +: 8];
          kn[d][w][i] = 1'b1;
        end
    if (!err && !we) begin
      rd = mm[d][w];
      for (int i = 0; i < 8; i++) cm[8*i +: 8] = {8{kn[d][w][i]}};
    end
  endfunction
  task automatic sel(input int d);
    case (d)
      0: vif = b0;
      1: vif = b1;
      default: vif = b2;
    endcase
  endtask
  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      sel(d);
      vif.req_valid = 0; vif.req_addr = '0; vif.req_we = 0;
      vif.req_wdata = '0; vif.req_mask = '0; vif.resp_ready = 0;
    end
  endtask
  task automatic txn(input logic [63:0] a, input logic we, input logic [63:0] wd, input logic [7:0] m,
                     input int hold, output logic [63:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    vif.req_valid = 1; vif.req_addr = a; vif.req_we = we;
    vif.req_wdata = wd; vif.req_mask = m; vif.resp_ready = 0;
    n = 0;
    while (!vif.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", vif.req_ready, 1);
    @(negedge clk);
    lat = 1;
    // Ignored traffic while busy: a stray full-word store to the same address.
    vif.req_valid = 1; vif.req_we = 1; vif.req_wdata = {$urandom(), $urandom()}; vif.req_mask = 8'hFF;
    while (!vif.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = vif.resp_rdata;
    er = vif.resp_err;
    for (int i = 0; i < hold; i++) begin
      vif.req_addr = {$urandom(), $urandom()} & 64'h78;
      @(negedge clk);
      chk("hold_valid", vif.resp_valid, 1);
      chk("hold_rdata", vif.resp_rdata, rd);
      chk("hold_err", vif.resp_err, er);
      chk("hold_req_ready", vif.req_ready, 0);
    end
    vif.req_valid = 0; vif.resp_ready = 1;
    @(negedge clk);
    vif.resp_ready = 0;
    chk("post_resp_valid", vif.resp_valid, 0);
    chk("post_req_ready", vif.req_ready, 1);
  endtask
  task automatic run(input int d, input logic [63:0] a, input logic we, input logic [63:0] wd,
                     input logic [7:0] m, input int hold);
    logic [63:0] erd, cm, rd;
    logic eerr, er;
    int lat;
    sel(d);
    model(d, a, we, wd, m, erd, eerr, cm);
    txn(a, we, wd, m, hold, rd, er, lat);
    chk("rdata", rd & cm, erd & cm);
    chk("err", er, eerr);
    chk("latency", 64'(lat), 64'(lat_of[d]));
  endtask
  task automatic stream(input int d);
    bit acc [40];
    int prev, L;
    sel(d);
    L = lat_of[d];
    prev = -1;
    @(negedge clk);
    vif.req_valid = 1; vif.req_we = 0; vif.req_addr = 64'h0; vif.resp_ready = 1;
    for (int t = 0; t < 30; t++) begin
      acc[t] = vif.req_valid && vif.req_ready;
      if (vif.resp_valid) chk("resp_after_accept", (t >= L) && acc[t-L], 1);
      if (acc[t]) begin
        if (prev >= 0) chk("accept_spacing", 64'(t - prev), 64'(L + 1));
        prev = t;
      end
      @(negedge clk);
    end
    vif.req_valid = 0;
    repeat (L + 2) @(negedge clk);
    vif.resp_ready = 0;
    chk("stream_idle", vif.req_ready, 1);
  endtask
  task automatic start_store(input logic [63:0] a, input logic [63:0] wd);
    int n;
    logic [63:0] erd, cm;
    logic eerr;
    @(negedge clk);
    vif.req_valid = 1; vif.req_addr = a; vif.req_we = 1; vif.req_wdata = wd; vif.req_mask = 8'hFF;
    n = 0;
    while (!vif.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("store_accept", vif.req_ready, 1);
    @(negedge clk);
    vif.req_valid = 0;
  endtask
  task automatic rst_pulse();
    int bad;
    #2 rst = 0;
    #1;
    chk("rst_resp_valid", vif.resp_valid, 0);
    chk("rst_rdata", vif.resp_rdata, 0);
    chk("rst_err", vif.resp_err, 0);
    chk("rst_req_ready", vif.req_ready, 0);
    @(posedge clk); #1;
    chk("rst_hold_ready", vif.req_ready, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rel_req_ready", vif.req_ready, 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (vif.resp_valid) bad++;
      @(negedge clk);
    end
    chk("no_resp_after_rst", 64'(bad), 0);
  endtask
  initial begin
    logic [63:0] rd, erd, cm, a;
    logic er, eerr;
    int lat, n, r;
    tbl[0]  = '{64'h10, 1'b1, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    tbl[1]  = '{64'h10, 1'b0, 64'h0,                8'h00, 64'h1122334455667788, 1'b0};
    tbl[2]  = '{64'h08, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'h0, 1'b0};
    tbl[3]  = '{64'h08, 1'b1, 64'h00000000000000BB, 8'h01, 64'h0, 1'b0};
    tbl[4]  = '{64'h08, 1'b0, 64'h0,                8'hFF, 64'hAAAAAAAAAAAAAABB, 1'b0};
    tbl[5]  = '{64'h0C, 1'b0, 64'h0,                8'hFF, 64'h0, 1'b1};
    tbl[6]  = '{64'h80, 1'b0, 64'h0,                8'hFF, 64'h0, 1'b1};
    tbl[7]  = '{64'h0C, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1};
    tbl[8]  = '{64'h88, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1};
    tbl[9]  = '{64'h08, 1'b0, 64'h0,                8'h00, 64'hAAAAAAAAAAAAAABB, 1'b0};
    tbl[10] = '{64'h10, 1'b1, 64'hDEADBEEFDEADBEEF, 8'h00, 64'h0, 1'b0};
    tbl[11] = '{64'h10, 1'b0, 64'h0,                8'h00, 64'h1122334455667788, 1'b0};
    for (int d = 0; d < 3; d++) for (int w = 0; w < 16; w++) begin mm[d][w] = '0; kn[d][w] = '0; end
    idle_all();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel(d);
      chk("reset_req_ready", vif.req_ready, 0);
      chk("reset_resp_valid", vif.resp_valid, 0);
      chk("reset_rdata", vif.resp_rdata, 0);
      chk("reset_err", vif.resp_err, 0);
    end
    rst = 1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin sel(d); chk("first_req_ready", vif.req_ready, 1); end
    sel(0);
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].m, 0, rd, er, lat);
      chk("tbl_rdata", rd, tbl[i].rd);
      chk("tbl_err", er, tbl[i].err);
      chk("tbl_latency", 64'(lat), 64'd2);
      model(0, tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].m, erd, eerr, cm);
    end
    run(0, 64'h10, 1'b0, 64'h0, 8'hFF, 5);
    run(0, 64'h10, 1'b0, 64'h0, 8'h00, 0);
    run(0, 64'h0C, 1'b0, 64'h0, 8'h00, 5);
    stream(1);
    stream(2);
    stream(0);
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 60; k++) begin
        r = $urandom_range(0, 9);
        if (r < 7) a = 64'($urandom_range(0, 15)) << 3;
        else if (r == 7) a = (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(1, 7));
        else if (r == 8) a = 64'd128 + (64'($urandom_range(0, 31)) << 3);
        else a = {$urandom(), $urandom()} | 64'h100;
        run(d, a, 1'($urandom()), {$urandom(), $urandom()}, 8'($urandom()), $urandom_range(0, 2));
      end
    sel(0);
    start_store(64'h18, 64'h0123456789ABCDEF);
    model(0, 64'h18, 1'b1, 64'h0123456789ABCDEF, 8'hFF, erd, eerr, cm);
    n = 0;
    while (!vif.resp_valid && n < 10) begin @(negedge clk); n++; end
    chk("resp_before_rst", vif.resp_valid, 1);
    rst_pulse();
    sel(2);
    start_store(64'h20, 64'hFEDCBA9876543210);
    model(2, 64'h20, 1'b1, 64'hFEDCBA9876543210, 8'hFF, erd, eerr, cm);
    chk("wait_no_resp", vif.resp_valid, 0);
    rst_pulse();
    run(2, 64'h20, 1'b0, 64'h0, 8'h00, 0);
    run(0, 64'h18, 1'b0, 64'h0, 8'h00, 0);
    run(0, 64'h08, 1'b0, 64'h0, 8'h00, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
